// File: rtl/level_fifo.sv
// Synchronous FIFO with fill level, thresholds, sticky error flags,
// flush, and selectable first-word-fall-through or registered read.
module level_fifo #(
  parameter int nrOfEntries      = 32,
  parameter int bitWidth         = 32,
  parameter int almostFullLevel  = 28,
  parameter int almostEmptyLevel = 4,
  parameter bit fwft             = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [bitWidth-1:0]          pushData,
  input  logic                         pop,
  output logic [bitWidth-1:0]          popData,
  output logic                         popValid,
  output logic                         full,
  output logic                         empty,
  output logic                         almostFull,
  output logic                         almostEmpty,
  output logic [$clog2(nrOfEntries):0] fillLevel,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(nrOfEntries);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] DEPTH = LW'(nrOfEntries);
  localparam logic [LW-1:0] AFL   = LW'(almostFullLevel);
  localparam logic [LW-1:0] AEL   = LW'(almostEmptyLevel);

  logic [bitWidth-1:0] mem [nrOfEntries];

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_next;
  logic [AW-1:0]       wr_next;
  logic [LW-1:0]       level_q;
  logic [LW-1:0]       level_rem;
  logic [LW-1:0]       level_next;
  logic                pop_ok;
  logic                push_ok;
  logic [bitWidth-1:0] data_q;
  logic [bitWidth-1:0] head_next;
  logic                valid_q;

  // Acceptance, next pointers, next level and next output word.
  // level_rem counts the old words still stored after this edge's pop;
  // when it is zero the only word left is the one being pushed now.
  always_comb begin
    pop_ok     = pop && (level_q != '0);
    push_ok    = push && ((level_q != DEPTH) || pop_ok);
    rd_next    = pop_ok  ? rd_ptr + AW'(1) : rd_ptr;
    wr_next    = push_ok ? wr_ptr + AW'(1) : wr_ptr;
    level_rem  = pop_ok  ? level_q - LW'(1) : level_q;
    level_next = push_ok ? level_rem + LW'(1) : level_rem;
    head_next  = data_q;
    if (fwft) begin
      if (level_next != '0) begin
        head_next = (level_rem == '0) ? pushData : mem[rd_next];
      end
    end else if (pop_ok) begin
      head_next = mem[rd_ptr];
    end
  end

  // Storage array; written only on accepted pushes.
  always_ff @(posedge clock) begin
    if (!reset && !clear && push_ok) begin
      mem[wr_ptr] <= pushData;
    end
  end

  // Pointers, level, flags and output register; flush keeps error flags.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level_q     <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      if (reset) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
    end else begin
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_next;
      level_q     <= level_next;
      full        <= (level_next == DEPTH);
      empty       <= (level_next == '0);
      almostFull  <= (level_next >= AFL);
      almostEmpty <= (level_next <= AEL);
      data_q      <= head_next;
      valid_q     <= fwft ? 1'b0 : pop_ok;
      overflow    <= overflow | (push && !push_ok);
      underflow   <= underflow | (pop && (level_q == '0));
    end
  end

  assign fillLevel = level_q;
  assign popData   = data_q;
  assign popValid  = fwft ? !empty : valid_q;

endmodule
